// File: rtl/booth_mac_acc.sv
// Accumulator behind the 16x16 Booth array: sums a programmed number of signed
// products into a wide register, with optional clamping, and hands the total out on valid/ready.
module booth_mac_acc #(
    parameter int PW  = 32,
    parameter int AW  = 40,
    parameter int CW  = 8,
    parameter int SAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CW-1:0]        len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [PW-1:0] prod,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [AW-1:0] acc_out,
    output logic                 sat,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                state;
    logic signed [AW-1:0]  acc_p1;
    logic [CW-1:0]         cnt;
    logic                  sat_p1;
    logic [AW:0]           sum_p0;

    // Returns {overflow, next accumulator}; the add is done one bit wider so
    // overflow shows up as disagreement between the two top bits.
    function automatic logic [AW:0] sat_add(input logic signed [AW-1:0] a,
                                            input logic signed [PW-1:0] p);
        logic signed [AW:0] sum;
        logic               ovf;
        logic [AW-1:0]      res;
        sum = {a[AW-1], a} + {{(AW + 1 - PW){p[PW-1]}}, p};
        ovf = sum[AW] ^ sum[AW-1];
        if (ovf && (SAT != 0))
            res = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        else
            res = sum[AW-1:0];
        return {ovf, res};
    endfunction

    // Stage p0: combinational add of the incoming product
    always_comb begin
        sum_p0 = sat_add(acc_p1, prod);
    end

    // Stage p1: control FSM and accumulator register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc_p1 <= '0;
            cnt    <= '0;
            sat_p1 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_p1 <= '0;
                        sat_p1 <= 1'b0;
                        if (len != '0) begin
                            cnt   <= len;
                            state <= ACCUM;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_p1 <= sum_p0[AW-1:0];
                        sat_p1 <= sat_p1 | sum_p0[AW];
                        cnt    <= cnt - CW'(1);
                        if (cnt == CW'(1))
                            state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign acc_out   = acc_p1;
    assign sat       = sat_p1;

endmodule

// File: tb/tb_booth_mac_acc.sv
// Scoreboard bench for booth_mac_acc: one 40-bit default instance plus two 34-bit
// instances (clamping and wrapping) share the same stimulus, each with its own expected queue.
module tb_booth_mac_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        in_valid = 1'b0;
    logic [31:0] prod = '0;
    logic        out_ready = 1'b0;

    logic        ir0, ov0, sat0, busy0;
    logic [39:0] acc0;
    logic        ir1, ov1, sat1, busy1;
    logic [33:0] acc1;
    logic        ir2, ov2, sat2, busy2;
    logic [33:0] acc2;

    int checks = 0;
    int errors = 0;
    int ir_cnt = 0;

    logic [40:0] q0[$];
    logic [34:0] q1[$];
    logic [34:0] q2[$];
    logic [31:0] pq[$];

    always #5 clk = ~clk;

    booth_mac_acc #(.PW(32), .AW(40), .CW(8), .SAT(1)) d0 (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
        .in_ready(ir0), .prod(prod), .out_valid(ov0), .out_ready(out_ready),
        .acc_out(acc0), .sat(sat0), .busy(busy0));

    booth_mac_acc #(.PW(32), .AW(34), .CW(8), .SAT(1)) d1 (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
        .in_ready(ir1), .prod(prod), .out_valid(ov1), .out_ready(out_ready),
        .acc_out(acc1), .sat(sat1), .busy(busy1));

    booth_mac_acc #(.PW(32), .AW(34), .CW(8), .SAT(0)) d2 (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
        .in_ready(ir2), .prod(prod), .out_valid(ov2), .out_ready(out_ready),
        .acc_out(acc2), .sat(sat2), .busy(busy2));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ov0"}, 64'(ov0), 64'd0);
        chk({tag, "_ir0"}, 64'(ir0), 64'd0);
        chk({tag, "_sat0"}, 64'(sat0), 64'd0);
        chk({tag, "_busy0"}, 64'(busy0), 64'd0);
        chk({tag, "_acc0"}, 64'(acc0), 64'd0);
        chk({tag, "_ov1"}, 64'(ov1), 64'd0);
        chk({tag, "_acc1"}, 64'(acc1), 64'd0);
        chk({tag, "_ov2"}, 64'(ov2), 64'd0);
        chk({tag, "_acc2"}, 64'(acc2), 64'd0);
    endtask

    // Monitor: compares the head of each queue every cycle the result is presented
    // (so stability under backpressure is covered) and pops on the handshake.
    task automatic monitor_step();
        if (ir0 === 1'b1) ir_cnt++;
        if (ov0 === 1'b1) begin
            if (q0.size() == 0) chk("unexpected_out0", 64'(ov0), 64'd0);
            else begin
                chk("acc0", 64'(acc0), 64'(q0[0][39:0]));
                chk("sat0", 64'(sat0), 64'(q0[0][40]));
                if (out_ready) void'(q0.pop_front());
            end
        end
        if (ov1 === 1'b1) begin
            if (q1.size() == 0) chk("unexpected_out1", 64'(ov1), 64'd0);
            else begin
                chk("acc1", 64'(acc1), 64'(q1[0][33:0]));
                chk("sat1", 64'(sat1), 64'(q1[0][34]));
                if (out_ready) void'(q1.pop_front());
            end
        end
        if (ov2 === 1'b1) begin
            if (q2.size() == 0) chk("unexpected_out2", 64'(ov2), 64'd0);
            else begin
                chk("acc2", 64'(acc2), 64'(q2[0][33:0]));
                chk("sat2", 64'(sat2), 64'(q2[0][34]));
                if (out_ready) void'(q2.pop_front());
            end
        end
    endtask

    // Presents one product and returns #1 after the edge that accepted it.
    task automatic send(input logic [31:0] p);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        prod = p;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (ir0 === 1'b1) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic run_job(input int nlen, input int gaps, input int hold, input bit poke,
                           input logic [40:0] e0, input logic [34:0] e1, input logic [34:0] e2);
        int exp_ir;
        q0.push_back(e0);
        q1.push_back(e1);
        q2.push_back(e2);
        @(posedge clk);
        #1;
        ir_cnt = 0;
        start = 1'b1;
        len = nlen[7:0];
        @(posedge clk);
        #1;
        if (poke) len = 8'd7;
        else start = 1'b0;
        for (int i = 0; i < nlen; i++) begin
            send(pq[i]);
            if (i < nlen - 1)
                repeat (gaps) begin @(posedge clk); #1; end
        end
        @(negedge clk);
        chk("latency_ov0", 64'(ov0), 64'd1);
        chk("latency_ov1", 64'(ov1), 64'd1);
        chk("latency_ov2", 64'(ov2), 64'd1);
        @(posedge clk);
        #1;
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("drop_ov0", 64'(ov0), 64'd0);
        chk("drop_ov1", 64'(ov1), 64'd0);
        chk("drop_ov2", 64'(ov2), 64'd0);
        exp_ir = (nlen == 0) ? 0 : nlen + gaps * (nlen - 1);
        chk("in_ready_cycles", 64'(ir_cnt), 64'(exp_ir));
        pq.delete();
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle("reset");

        // Reset abandons a job in flight: two of four products in, then rst.
        @(posedge clk);
        #1;
        start = 1'b1;
        len = 8'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        send(32'd100);
        send(32'd200);
        @(negedge clk);
        chk("mid_busy0", 64'(busy0), 64'd1);
        chk("mid_acc0", 64'(acc0), 64'd300);
        chk("mid_acc2", 64'(acc2), 64'd300);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle("midreset");
        repeat (4) @(negedge clk);
        chk_idle("postreset");

        // -15 + 20 + 6 = 11
        pq = '{32'hFFFF_FFF1, 32'h0000_0014, 32'h0000_0006};
        run_job(3, 0, 0, 1'b0, {1'b0, 40'h00_0000_000B}, {1'b0, 34'h0_0000_000B},
                {1'b0, 34'h0_0000_000B});

        // 2 * 2^30 with input gaps and 5 cycles of backpressure
        pq = '{32'h4000_0000, 32'h4000_0000};
        run_job(2, 2, 5, 1'b0, {1'b0, 40'h00_8000_0000}, {1'b0, 34'h0_8000_0000},
                {1'b0, 34'h0_8000_0000});

        // 8 * 2^30 = 2^33: fits 40 bits, clamps or wraps at 34 bits
        for (int i = 0; i < 8; i++) pq.push_back(32'h4000_0000);
        run_job(8, 0, 1, 1'b0, {1'b0, 40'h02_0000_0000}, {1'b1, 34'h1_FFFF_FFFF},
                {1'b1, 34'h2_0000_0000});

        // 9 * -2^30: 40-bit exact, 34-bit clamps at -2^33 or wraps to 7 * 2^30
        for (int i = 0; i < 9; i++) pq.push_back(32'hC000_0000);
        run_job(9, 0, 0, 1'b0, {1'b0, 40'hFD_C000_0000}, {1'b1, 34'h2_0000_0000},
                {1'b1, 34'h1_C000_0000});

        // len = 0: immediate zero result, sticky flag cleared by the new start
        run_job(0, 0, 2, 1'b0, {1'b0, 40'h0}, {1'b0, 34'h0}, {1'b0, 34'h0});

        // start held high through ACCUM and HOLD must be ignored: 5 + -3 = 2
        pq = '{32'h0000_0005, 32'hFFFF_FFFD};
        run_job(2, 1, 2, 1'b1, {1'b0, 40'h2}, {1'b0, 34'h2}, {1'b0, 34'h2});

        repeat (3) @(negedge clk);
        chk("final_idle_ov0", 64'(ov0), 64'd0);
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q2_drained", 64'(q2.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
